// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one single-port, synchronous-read data RAM between two requesters
// (e.g. CPU core on port 0, debug/loader engine on port 1). One transaction is
// in flight at a time; RAM address, write data and write strobe come straight
// from registers, and read data returns a fixed two edges after the grant.
//
// Build option:
//   DMA_ARB_RR_EN  defined   -> round-robin on a tie (port not last served wins)
//                  undefined -> fixed priority, port 0 wins every tie; no
//                               last-served state exists in this build
//
// Ports:
//   _iClk, _iResetN       clock (rising edge), asynchronous active-low reset
//   _iReq[1:0], _iWe[1:0] per-port request / write enable (bit i = port i)
//   _iAddr0/1, _iWData0/1 per-port address and write data
//   _oGnt[1:0]            one-hot grant pulse (registered)
//   _oRValid[1:0]         one-hot read-data-valid pulse (registered)
//   _oRData               read data, shared, held between _oRValid pulses
//   _oMemAddr/_oMemWData  RAM address / write data (registered, hold when idle)
//   _oMemWrite            RAM write strobe, one cycle per write
//   _iMemRData            RAM read data, valid the cycle after the address
//   _oBusy                high whenever the FSM is not IDLE
//   _oDbgState            FSM state for checkers: 0 IDLE, 1 ISSUE, 2 READ
//
// Handshake: a requester holds req/we/addr/wdata stable until it sees its
// _oGnt bit; in the cycle after the grant it may drop req or present a new
// request. Dropping req before a grant is legal and causes no RAM access.
// _oRValid is a single-cycle pulse with no back-pressure; _oRData is
// meaningful only while _oRValid is set.
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              _iClk,
   input  logic              _iResetN,
   input  logic [1:0]        _iReq,
   input  logic [1:0]        _iWe,
   input  logic [ADDR_W-1:0] _iAddr0,
   input  logic [ADDR_W-1:0] _iAddr1,
   input  logic [DATA_W-1:0] _iWData0,
   input  logic [DATA_W-1:0] _iWData1,
   output logic [1:0]        _oGnt,
   output logic [1:0]        _oRValid,
   output logic [DATA_W-1:0] _oRData,
   output logic [ADDR_W-1:0] _oMemAddr,
   output logic [DATA_W-1:0] _oMemWData,
   output logic              _oMemWrite,
   input  logic [DATA_W-1:0] _iMemRData,
   output logic              _oBusy,
   output logic [1:0]        _oDbgState
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      READ  = 2'd2
   } stateT;

   stateT state;
   logic  owner;     // port that owns the transaction in flight
   logic  winner;    // port selected this cycle (meaningful only if |_iReq)

`ifdef DMA_ARB_RR_EN
   logic  lastServed;
`endif

   // With a single requester ~_iReq[0] picks it (01 -> 0, 10 -> 1).
   always_comb begin
      winner = ~_iReq[0];
`ifdef DMA_ARB_RR_EN
      if (_iReq == 2'b11)
         winner = ~lastServed;
`endif
   end

   always_ff @(posedge _iClk or negedge _iResetN) begin
      if (!_iResetN) begin
         state      <= IDLE;
         owner      <= 1'b0;
         _oGnt      <= 2'b00;
         _oRValid   <= 2'b00;
         _oRData    <= '0;
         _oMemAddr  <= '0;
         _oMemWData <= '0;
         _oMemWrite <= 1'b0;
`ifdef DMA_ARB_RR_EN
         // Pointing at port 1 makes port 0 win the first tie.
         lastServed <= 1'b1;
`endif
      end else begin
         _oRValid <= 2'b00;
         case (state)
            IDLE: begin
               if (|_iReq) begin
                  _oMemAddr  <= winner ? _iAddr1  : _iAddr0;
                  _oMemWData <= winner ? _iWData1 : _iWData0;
                  _oMemWrite <= _iWe[winner];
                  _oGnt      <= {winner, ~winner};
                  owner      <= winner;
`ifdef DMA_ARB_RR_EN
                  lastServed <= winner;
`endif
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               // _oMemWrite still carries this transaction's direction here.
               _oGnt      <= 2'b00;
               _oMemWrite <= 1'b0;
               state      <= _oMemWrite ? IDLE : READ;
            end
            READ: begin
               _oRData  <= _iMemRData;
               _oRValid <= {owner, ~owner};
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign _oBusy     = (state != IDLE);
   assign _oDbgState = state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Bench for data_mem_arbiter with a behavioural synchronous-read RAM attached.
// Directed table of single transactions, hand-written contention / hazard /
// mid-read reset sequences, then randomized traffic checked against a
// transaction-level model (busy-until time, shadow memory, read-data queue).
// Honours DMA_ARB_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;

   logic          _iClk = 1'b0;
   logic          _iResetN;
   logic [1:0]    _iReq;
   logic [1:0]    _iWe;
   logic [AW-1:0] _iAddr0, _iAddr1;
   logic [DW-1:0] _iWData0, _iWData1;
   logic [1:0]    _oGnt, _oRValid;
   logic [DW-1:0] _oRData;
   logic [AW-1:0] _oMemAddr;
   logic [DW-1:0] _oMemWData;
   logic          _oMemWrite;
   logic [DW-1:0] _iMemRData;
   logic          _oBusy;
   logic [1:0]    _oDbgState;

   int total = 0;
   int bad   = 0;

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      ._iClk(_iClk), ._iResetN(_iResetN),
      ._iReq(_iReq), ._iWe(_iWe),
      ._iAddr0(_iAddr0), ._iAddr1(_iAddr1),
      ._iWData0(_iWData0), ._iWData1(_iWData1),
      ._oGnt(_oGnt), ._oRValid(_oRValid), ._oRData(_oRData),
      ._oMemAddr(_oMemAddr), ._oMemWData(_oMemWData), ._oMemWrite(_oMemWrite),
      ._iMemRData(_iMemRData), ._oBusy(_oBusy), ._oDbgState(_oDbgState)
   );

   // ---------------- clock / RAM ----------------
   always #5 _iClk = ~_iClk;

   logic [DW-1:0] ram [256];
   logic          ramInit;

   always @(posedge _iClk) begin
      if (ramInit) begin
         for (int i = 0; i < 256; i++) ram[i] <= '0;
      end else begin
         if (_oMemWrite) ram[_oMemAddr] <= _oMemWData;
         _iMemRData <= ram[_oMemAddr];
      end
   end

   // ---------------- scoreboard / model state ----------------
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] shadow [256];
   int            cyc, freeAt, rvAt;
   logic          rvPort, lastServed;
   logic [AW-1:0] mAddr;
   logic [DW-1:0] mWData, mRData;
   logic [1:0]    expGnt, expRv;
   logic          expWr, expBusy;
   logic [1:0]    pend, pWe;
   logic [AW-1:0] pAddr [2];
   logic [DW-1:0] pData [2];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idleInputs();
      _iReq = 2'b00; _iWe = 2'b00;
      _iAddr0 = '0; _iAddr1 = '0; _iWData0 = '0; _iWData1 = '0;
   endtask

   task automatic applyReset();
      idleInputs();
      _iResetN = 1'b0;
      repeat (2) @(posedge _iClk);
      @(negedge _iClk);
      _iResetN = 1'b1;
   endtask

   task automatic modelReset();
      exp_q.delete();
      cyc = 0; freeAt = 0; rvAt = -100; rvPort = 1'b0;
      lastServed = 1'b1;
      mAddr = '0; mWData = '0; mRData = '0;
      pend = 2'b00; pWe = 2'b00;
   endtask

   // Transaction-level view: the arbiter accepts one request per free slot;
   // a write occupies 2 cycles, a read 3, read data appears 2 edges later.
   task automatic modelEdge();
      logic w;
      expGnt = 2'b00;
      expWr  = 1'b0;
      if (cyc >= freeAt && _iReq != 2'b00) begin
         if (_iReq == 2'b01)      w = 1'b0;
         else if (_iReq == 2'b10) w = 1'b1;
         else begin
`ifdef DMA_ARB_RR_EN
            w = (lastServed == 1'b1) ? 1'b0 : 1'b1;
`else
            w = 1'b0;
`endif
         end
         lastServed = w;
         expGnt = w ? 2'b10 : 2'b01;
         mAddr  = w ? _iAddr1 : _iAddr0;
         mWData = w ? _iWData1 : _iWData0;
         expWr  = _iWe[w];
         if (_iWe[w]) begin
            shadow[mAddr] = mWData;
            freeAt = cyc + 2;
         end else begin
            exp_q.push_back(shadow[mAddr]);
            rvAt   = cyc + 2;
            rvPort = w;
            freeAt = cyc + 3;
         end
         pend[w] = 1'b0;
      end
      expRv = (cyc == rvAt) ? (rvPort ? 2'b10 : 2'b01) : 2'b00;
      if (expRv != 2'b00) begin
         if (exp_q.size() > 0) mRData = exp_q.pop_front();
      end
      expBusy = (cyc + 1 < freeAt);
   endtask

   task automatic randomPhase(input int cycles, input bit allowNew);
      for (int c = 0; c < cycles; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
               if (allowNew && $urandom_range(0, 2) == 0) begin
                  pend[p]  = 1'b1;
                  pWe[p]   = 1'($urandom_range(0, 1));
                  pAddr[p] = 8'h60 + 8'($urandom_range(0, 15));
                  pData[p] = 8'($urandom_range(0, 255));
               end
            end else if ($urandom_range(0, 15) == 0) begin
               pend[p] = 1'b0;   // withdrawn before grant
            end
         end
         _iReq = pend; _iWe = pWe;
         _iAddr0 = pAddr[0]; _iAddr1 = pAddr[1];
         _iWData0 = pData[0]; _iWData1 = pData[1];
         @(posedge _iClk);
         cyc++;
         modelEdge();
         #1;
         check("rnd_gnt",   8'(_oGnt),      8'(expGnt));
         check("rnd_wr",    8'(_oMemWrite), 8'(expWr));
         check("rnd_addr",  _oMemAddr,      mAddr);
         check("rnd_wdata", _oMemWData,     mWData);
         check("rnd_busy",  8'(_oBusy),     8'(expBusy));
         check("rnd_rv",    8'(_oRValid),   8'(expRv));
         check("rnd_rdata", _oRData,        mRData);
      end
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [1:0]    req, we;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic [1:0]    gnt;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          wr;
      logic [DW-1:0] rdata;
   } vecT;

   vecT vecs [10];

   task automatic applyVec(input vecT v);
      _iReq = v.req; _iWe = v.we;
      _iAddr0 = v.a0; _iAddr1 = v.a1; _iWData0 = v.d0; _iWData1 = v.d1;
      @(posedge _iClk); #1;
      check("tab_gnt",   8'(_oGnt),      8'(v.gnt));
      check("tab_addr",  _oMemAddr,      v.addr);
      check("tab_wdata", _oMemWData,     v.wdata);
      check("tab_wr",    8'(_oMemWrite), 8'(v.wr));
      check("tab_busy",  8'(_oBusy),     8'h01);
      idleInputs();
      @(posedge _iClk); #1;
      check("tab_gnt_off", 8'(_oGnt),      8'h00);
      check("tab_wr_off",  8'(_oMemWrite), 8'h00);
      if (!v.wr) begin
         check("tab_rv_early", 8'(_oRValid), 8'h00);
         @(posedge _iClk); #1;
         check("tab_rv",    8'(_oRValid), 8'(v.gnt));
         check("tab_rdata", _oRData,      v.rdata);
      end
      check("tab_idle", 8'(_oBusy), 8'h00);
   endtask

   // ---------------- main ----------------
   initial begin
      logic w;
      for (int i = 0; i < 256; i++) shadow[i] = '0;
      ramInit = 1'b1;
      idleInputs();
      _iResetN = 1'b0;
      @(posedge _iClk); #1;
      ramInit = 1'b0;
      check("rst_gnt",   8'(_oGnt),      8'h00);
      check("rst_rv",    8'(_oRValid),   8'h00);
      check("rst_wr",    8'(_oMemWrite), 8'h00);
      check("rst_busy",  8'(_oBusy),     8'h00);
      check("rst_addr",  _oMemAddr,      8'h00);
      check("rst_rdata", _oRData,        8'h00);
      check("rst_state", 8'(_oDbgState), 8'h00);
      applyReset();

      vecs[0] = '{2'b01, 2'b01, 8'h3C, 8'h00, 8'hA5, 8'h00, 2'b01, 8'h3C, 8'hA5, 1'b1, 8'h00};
      vecs[1] = '{2'b10, 2'b10, 8'h00, 8'h10, 8'h00, 8'h7E, 2'b10, 8'h10, 8'h7E, 1'b1, 8'h00};
      vecs[2] = '{2'b10, 2'b00, 8'h00, 8'h10, 8'h00, 8'h99, 2'b10, 8'h10, 8'h99, 1'b0, 8'h7E};
      vecs[3] = '{2'b01, 2'b00, 8'h3C, 8'h00, 8'h11, 8'h00, 2'b01, 8'h3C, 8'h11, 1'b0, 8'hA5};
`ifdef DMA_ARB_RR_EN
      vecs[4] = '{2'b11, 2'b11, 8'h44, 8'h45, 8'hC3, 8'h3D, 2'b10, 8'h45, 8'h3D, 1'b1, 8'h00};
      vecs[5] = '{2'b11, 2'b00, 8'h45, 8'h44, 8'h00, 8'h00, 2'b01, 8'h45, 8'h00, 1'b0, 8'h3D};
`else
      vecs[4] = '{2'b11, 2'b11, 8'h44, 8'h45, 8'hC3, 8'h3D, 2'b01, 8'h44, 8'hC3, 1'b1, 8'h00};
      vecs[5] = '{2'b11, 2'b00, 8'h44, 8'h45, 8'h00, 8'h00, 2'b01, 8'h44, 8'h00, 1'b0, 8'hC3};
`endif
      vecs[6] = '{2'b01, 2'b01, 8'hFF, 8'h00, 8'h5A, 8'h00, 2'b01, 8'hFF, 8'h5A, 1'b1, 8'h00};
      vecs[7] = '{2'b10, 2'b00, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b10, 8'hFF, 8'h00, 1'b0, 8'h5A};
      vecs[8] = '{2'b01, 2'b01, 8'h00, 8'h00, 8'hFF, 8'h00, 2'b01, 8'h00, 8'hFF, 1'b1, 8'h00};
      vecs[9] = '{2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 8'h00, 8'h00, 1'b0, 8'hFF};
      for (int i = 0; i < 10; i++) applyVec(vecs[i]);

      // Reset while a port-1 read is in READ: everything clears at once,
      // and the read never completes.
      _iReq = 2'b10; _iWe = 2'b00; _iAddr1 = 8'h10;
      @(posedge _iClk); #1;
      check("mr_gnt", 8'(_oGnt), 8'h02);
      idleInputs();
      @(posedge _iClk); #2;
      _iResetN = 1'b0;
      #1;
      check("mr_gnt0",   8'(_oGnt),      8'h00);
      check("mr_rv0",    8'(_oRValid),   8'h00);
      check("mr_wr0",    8'(_oMemWrite), 8'h00);
      check("mr_busy0",  8'(_oBusy),     8'h00);
      check("mr_addr0",  _oMemAddr,      8'h00);
      check("mr_wdata0", _oMemWData,     8'h00);
      check("mr_rdata0", _oRData,        8'h00);
      repeat (2) @(posedge _iClk);
      #1;
      check("mr_rv_hold", 8'(_oRValid), 8'h00);
      @(negedge _iClk);
      _iResetN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge _iClk); #1;
         check("mr_rv_after", 8'(_oRValid),   8'h00);
         check("mr_state",    8'(_oDbgState), 8'h00);
      end

      // Continuous contention of writes from both ports.
      applyReset();
      begin
         logic [AW-1:0] a0, a1;
         a0 = 8'h80; a1 = 8'hC0;
         _iReq = 2'b11; _iWe = 2'b11; _iAddr0 = a0; _iAddr1 = a1;
         _iWData0 = 8'h01; _iWData1 = 8'h02;
         for (int g = 0; g < 4; g++) begin
            @(posedge _iClk); #1;
`ifdef DMA_ARB_RR_EN
            w = g[0];
`else
            w = 1'b0;
`endif
            check("cont_gnt",  8'(_oGnt),      w ? 8'h02 : 8'h01);
            check("cont_addr", _oMemAddr,      w ? a1 : a0);
            check("cont_wr",   8'(_oMemWrite), 8'h01);
            if (w) begin a1 = a1 + 8'd1; _iAddr1 = a1; end
            else   begin a0 = a0 + 8'd1; _iAddr0 = a0; end
            @(posedge _iClk); #1;
            check("cont_gap", 8'(_oGnt), 8'h00);
         end
         _iReq = 2'b10;
         @(posedge _iClk); #1;
         check("cont_p1_gnt",  8'(_oGnt), 8'h02);
         check("cont_p1_addr", _oMemAddr, a1);
         idleInputs();
         @(posedge _iClk); #1;
      end

      // Write then immediate read of the same address from the other port.
      _iReq = 2'b11; _iWe = 2'b01; _iAddr0 = 8'h20; _iWData0 = 8'h55; _iAddr1 = 8'h20;
      @(posedge _iClk); #1;
      check("haz_gnt0", 8'(_oGnt), 8'h01);
      _iReq = 2'b10; _iWe = 2'b00;
      @(posedge _iClk); #1;
      check("haz_rv_k1", 8'(_oRValid), 8'h00);
      @(posedge _iClk); #1;
      check("haz_gnt1", 8'(_oGnt), 8'h02);
      idleInputs();
      @(posedge _iClk); #1;
      check("haz_rv_k3", 8'(_oRValid), 8'h00);
      @(posedge _iClk); #1;
      check("haz_rv_k4", 8'(_oRValid), 8'h02);
      check("haz_rdata", _oRData,      8'h55);

      // Randomized traffic against the model.
      applyReset();
      modelReset();
      randomPhase(600, 1'b1);
      randomPhase(8, 1'b0);
      check("drain_q", 8'(exp_q.size()), 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
